// File: rtl/apf_keypad_if.sv
// apf_keypad_if: bundles the PS/2 event input, the PIA row/column scan signals
// and the fire / any-key outputs of the APF MP1000 keypad translator.
// master = the side feeding key events and row selects (MiSTer top / PIA).
// slave  = the keypad translator itself.
interface apf_keypad_if;
  logic [10:0] ps2_key;
  logic        release_all;
  logic [3:0]  row_sel_n;
  logic [7:0]  col_n;
  logic [1:0]  fire_n;
  logic        any_key_n;

  modport master (
    output ps2_key, release_all, row_sel_n,
    input  col_n, fire_n, any_key_n
  );

  modport slave (
    input  ps2_key, release_all, row_sel_n,
    output col_n, fire_n, any_key_n
  );
endinterface

// File: rtl/apf_keypad.sv
// apf_keypad: PS/2 set-2 key events -> two APF MP1000 hand-controller
// matrices (4 rows x 4 cols each) plus fire buttons, scanned by the PIA.
// Column data is active low; selected rows are wired-AND onto the columns.
// Optional build macro APF_KEYPAD_AUTOFIRE_EN: fire buttons pulse at a rate
// set by AUTOFIRE_DIV while held instead of following the key directly.
module apf_keypad #(
  parameter logic [23:0] AUTOFIRE_DIV = 24'd1_000_000
) (
  input  logic         clk_sys,
  input  logic         reset,
  apf_keypad_if.slave  kp
);

  logic              prev_strobe;
  logic [6:0]        dec;        // {hit, ctl, fire, idx[3:0]}
  logic              key_ev;
  logic              key_ctl;
  logic              key_fire;
  logic [3:0]        key_idx;
  logic              key_press;
  logic [1:0][15:0]  mat;        // per controller, bit = row*4 + col
  logic [1:0]        fire_st;
  logic [7:0]        col_nxt;
  logic [1:0]        fire_nxt;
  logic              any_nxt;

  // A zero divisor would make the autofire wrap compare underflow; nothing
  // is built here, the block only documents that the value must be nonzero.
  if (AUTOFIRE_DIV == 24'd0) begin : g_autofire_div_must_be_nonzero
  end

  // Map {ext, code} to controller / fire / matrix position; unmapped -> no hit.
  always_comb begin
    dec = 7'h00;
    case ({kp.ps2_key[8], kp.ps2_key[7:0]})
      9'h016: dec = 7'h40;  9'h01E: dec = 7'h41;  9'h026: dec = 7'h42;  9'h175: dec = 7'h43;
      9'h025: dec = 7'h44;  9'h02E: dec = 7'h45;  9'h036: dec = 7'h46;  9'h172: dec = 7'h47;
      9'h03D: dec = 7'h48;  9'h03E: dec = 7'h49;  9'h046: dec = 7'h4A;  9'h16B: dec = 7'h4B;
      9'h066: dec = 7'h4C;  9'h045: dec = 7'h4D;  9'h05A: dec = 7'h4E;  9'h174: dec = 7'h4F;
      9'h014: dec = 7'h50;
      9'h069: dec = 7'h60;  9'h072: dec = 7'h61;  9'h07A: dec = 7'h62;  9'h01D: dec = 7'h63;
      9'h06B: dec = 7'h64;  9'h073: dec = 7'h65;  9'h074: dec = 7'h66;  9'h01B: dec = 7'h67;
      9'h06C: dec = 7'h68;  9'h075: dec = 7'h69;  9'h07D: dec = 7'h6A;  9'h01C: dec = 7'h6B;
      9'h071: dec = 7'h6C;  9'h070: dec = 7'h6D;  9'h15A: dec = 7'h6E;  9'h023: dec = 7'h6F;
      9'h029: dec = 7'h70;
      default: dec = 7'h00;
    endcase
  end

  assign key_ev    = (kp.ps2_key[10] != prev_strobe) && dec[6];
  assign key_ctl   = dec[5];
  assign key_fire  = dec[4];
  assign key_idx   = dec[3:0];
  assign key_press = kp.ps2_key[9];

  // Track the event toggle every cycle, including during release_all.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) prev_strobe <= 1'b0;
    else       prev_strobe <= kp.ps2_key[10];
  end

  // Per-key held state; release_all wins over a coincident event.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      mat     <= '0;
      fire_st <= '0;
    end else if (kp.release_all) begin
      mat     <= '0;
      fire_st <= '0;
    end else if (key_ev) begin
      if (key_fire) fire_st[key_ctl]       <= key_press;
      else          mat[key_ctl][key_idx]  <= key_press;
    end
  end

`ifdef APF_KEYPAD_AUTOFIRE_EN
  logic [1:0][23:0] af_cnt;
  logic [1:0]       af_phase;
  logic [1:0]       af_start;
  logic [1:0]       af_stop;

  // Press edge restarts the pulse train; release stops it at once.
  always_comb begin
    af_start = '0;
    af_stop  = '0;
    for (int i = 0; i < 2; i++) begin
      af_start[i] = key_ev && key_fire && (key_ctl == 1'(i)) && key_press && !fire_st[i];
      af_stop[i]  = key_ev && key_fire && (key_ctl == 1'(i)) && !key_press;
    end
  end

  // Autofire divider: phase flips each time the counter wraps while held.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      af_cnt   <= '0;
      af_phase <= '0;
    end else if (kp.release_all) begin
      af_cnt   <= '0;
      af_phase <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (af_start[i]) begin
          af_cnt[i]   <= '0;
          af_phase[i] <= 1'b1;
        end else if (af_stop[i] || !fire_st[i]) begin
          af_cnt[i]   <= '0;
          af_phase[i] <= 1'b0;
        end else if (af_cnt[i] == AUTOFIRE_DIV - 24'd1) begin
          af_cnt[i]   <= '0;
          af_phase[i] <= ~af_phase[i];
        end else begin
          af_cnt[i]   <= af_cnt[i] + 24'd1;
        end
      end
    end
  end
`endif

  // Next output values: wired-AND of selected rows per column.
  always_comb begin
    col_nxt = 8'hFF;
    for (int k = 0; k < 2; k++)
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++)
          if (!kp.row_sel_n[r] && mat[k][r*4 + c]) col_nxt[k*4 + c] = 1'b0;
`ifdef APF_KEYPAD_AUTOFIRE_EN
    fire_nxt = ~af_phase;
`else
    fire_nxt = ~fire_st;
`endif
    any_nxt = ~((|mat) | (|fire_st));
  end

  // Registered outputs toward the PIA.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      kp.col_n     <= 8'hFF;
      kp.fire_n    <= 2'b11;
      kp.any_key_n <= 1'b1;
    end else begin
      kp.col_n     <= col_nxt;
      kp.fire_n    <= fire_nxt;
      kp.any_key_n <= any_nxt;
    end
  end

endmodule

// File: tb/tb_apf_keypad.sv
// tb_apf_keypad: directed, table-driven check of the APF keypad translator,
// plus hand sequences for latency, release_all, reset and autofire.
module tb_apf_keypad;

  logic clk_sys = 1'b0;
  logic reset   = 1'b1;
  logic tgl     = 1'b0;
  int   errors  = 0;
  int   checks  = 0;

  apf_keypad_if kif ();

  apf_keypad #(.AUTOFIRE_DIV(24'd4)) dut (
    .clk_sys (clk_sys),
    .reset   (reset),
    .kp      (kif)
  );

  always #5 clk_sys = ~clk_sys;

  typedef struct {
    string      name;
    logic       press;
    logic       ext;
    logic [7:0] code;
    logic [3:0] row;
    logic [7:0] exp_col;
    logic [1:0] exp_fire;
    logic       exp_any;
  } vec_t;

  vec_t vecs [17];

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_all(input string name, input logic [7:0] col, input logic [1:0] fire,
                           input logic any);
    check({name, " col_n"}, kif.col_n, col);
    check({name, " fire_n"}, {6'd0, kif.fire_n}, {6'd0, fire});
    check({name, " any_key_n"}, {7'd0, kif.any_key_n}, {7'd0, any});
  endtask

  task automatic send(input logic press, input logic ext, input logic [7:0] code);
    tgl = ~tgl;
    kif.ps2_key = {tgl, press, ext, code};
  endtask

  initial begin
    vecs[0]  = '{"p_2",        1, 0, 8'h1E, 4'b1110, 8'hFD, 2'b11, 0};
    vecs[1]  = '{"r_2",        0, 0, 8'h1E, 4'b1110, 8'hFF, 2'b11, 1};
    vecs[2]  = '{"p_up1",      1, 1, 8'h75, 4'b1110, 8'hF7, 2'b11, 0};
    vecs[3]  = '{"p_kp8",      1, 0, 8'h75, 4'b1110, 8'hF7, 2'b11, 0};
    vecs[4]  = '{"rep_up1",    1, 1, 8'h75, 4'b1011, 8'hDF, 2'b11, 0};
    vecs[5]  = '{"r_up1",      0, 1, 8'h75, 4'b1110, 8'hFF, 2'b11, 0};
    vecs[6]  = '{"r_kp8",      0, 0, 8'h75, 4'b1011, 8'hFF, 2'b11, 1};
    vecs[7]  = '{"r_kp8_again",0, 0, 8'h75, 4'b0000, 8'hFF, 2'b11, 1};
    vecs[8]  = '{"p_1",        1, 0, 8'h16, 4'b1010, 8'hFE, 2'b11, 0};
    vecs[9]  = '{"p_7",        1, 0, 8'h3D, 4'b1010, 8'hFE, 2'b11, 0};
    vecs[10] = '{"p_down1",    1, 1, 8'h72, 4'b1111, 8'hFF, 2'b11, 0};
    vecs[11] = '{"p_fire1",    1, 0, 8'h14, 4'b0000, 8'hF6, 2'b10, 0};
    vecs[12] = '{"r_fire1",    0, 0, 8'h14, 4'b0000, 8'hF6, 2'b11, 0};
    vecs[13] = '{"p_ent2",     1, 1, 8'h5A, 4'b0111, 8'hBF, 2'b11, 0};
    vecs[14] = '{"p_ent1",     1, 0, 8'h5A, 4'b0111, 8'hBB, 2'b11, 0};
    vecs[15] = '{"p_unmapped", 1, 0, 8'h12, 4'b0111, 8'hBB, 2'b11, 0};
    vecs[16] = '{"p_d2",       1, 0, 8'h23, 4'b0111, 8'h3B, 2'b11, 0};

    kif.ps2_key     = 11'h000;
    kif.release_all = 1'b0;
    kif.row_sel_n   = 4'hF;

    // Reset values.
    tick();
    tick();
    check_all("reset", 8'hFF, 2'b11, 1'b1);
    reset = 1'b0;
    tick();
    check_all("post_reset", 8'hFF, 2'b11, 1'b1);

    // Event latency (2 cycles) and row select latency (1 cycle), key "3" r0c2.
    kif.row_sel_n = 4'b1110;
    send(1'b1, 1'b0, 8'h26);
    tick();
    check("lat_ev_1cyc", kif.col_n, 8'hFF);
    tick();
    check("lat_ev_2cyc", kif.col_n, 8'hFB);
    kif.row_sel_n = 4'b1111;
    tick();
    check("lat_row_off", kif.col_n, 8'hFF);
    kif.row_sel_n = 4'b1110;
    tick();
    check("lat_row_on", kif.col_n, 8'hFB);
    send(1'b0, 1'b0, 8'h26);
    tick();
    tick();
    check_all("r_3", 8'hFF, 2'b11, 1'b1);

    // Table of key events; state accumulates across vectors.
    for (int i = 0; i < 17; i++) begin
      kif.row_sel_n = vecs[i].row;
      send(vecs[i].press, vecs[i].ext, vecs[i].code);
      tick();
      tick();
      check_all(vecs[i].name, vecs[i].exp_col, vecs[i].exp_fire, vecs[i].exp_any);
    end

    // release_all together with a press of controller 2 fire.
    kif.row_sel_n = 4'b0000;
    send(1'b1, 1'b0, 8'h29);
    kif.release_all = 1'b1;
    tick();
    kif.release_all = 1'b0;
    tick();
    tick();
    check_all("release_all", 8'hFF, 2'b11, 1'b1);

    // Reset mid-stream with keys held and an event in flight.
    send(1'b1, 1'b0, 8'h16);
    tick();
    send(1'b1, 1'b0, 8'h14);
    tick();
    tick();
    check_all("pre_reset_held", 8'hFE, 2'b10, 1'b0);
    send(1'b1, 1'b0, 8'h1E);
    reset = 1'b1;
    #1;
    check_all("in_reset", 8'hFF, 2'b11, 1'b1);
    tgl = 1'b0;
    kif.ps2_key = 11'h000;
    tick();
    reset = 1'b0;
    tick();
    tick();
    check_all("after_reset", 8'hFF, 2'b11, 1'b1);

`ifdef APF_KEYPAD_AUTOFIRE_EN
    // Autofire with divider 4: four updates low, four high, then low again.
    send(1'b1, 1'b0, 8'h14);
    tick();
    for (int k = 0; k < 9; k++) begin
      tick();
      check($sformatf("autofire_%0d", k), {7'd0, kif.fire_n[0]},
            {7'd0, (k >= 4 && k < 8)});
    end
    send(1'b0, 1'b0, 8'h14);
    tick();
    tick();
    check("autofire_release", {6'd0, kif.fire_n}, 8'h03);
`else
    // Plain fire: held fire stays low across many cycles, then releases.
    send(1'b1, 1'b0, 8'h14);
    tick();
    for (int k = 0; k < 9; k++) begin
      tick();
      check($sformatf("fire_hold_%0d", k), {6'd0, kif.fire_n}, 8'h02);
    end
    send(1'b0, 1'b0, 8'h14);
    tick();
    tick();
    check("fire_release", {6'd0, kif.fire_n}, 8'h03);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
